// File: rtl/mem_bus_arbiter_pkg.sv
// arb_pkg: shared state, owner and counter-width encodings for mem_bus_arbiter
package arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;
  localparam int LAT_W = 3;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester handshakes and memory port bundled for the arbiter
interface mem_bus_arbiter_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_done;
  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_done;
  logic              halt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, halt, mem_rdata,
    output cpu_done, ldr_done, mem_en, mem_we, mem_addr, mem_wdata, rdata, busy
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, halt, mem_rdata,
    input  cpu_done, ldr_done, mem_en, mem_we, mem_addr, mem_wdata, rdata, busy
  );
endinterface

// File: rtl/mem_bus_arbiter_lat_counter.sv
// lat_counter: loadable down-counter timing the memory read latency
module lat_counter
  import arb_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [LAT_W-1:0] value,
  output logic             zero
);
  logic [LAT_W-1:0] count;
  // load on issue, count down while waiting, never wrap below zero
  always_ff @(posedge clock or posedge clear)
    if (clear) count <= '0;
    else if (load) count <= value;
    else if (dec && count != '0) count <= count - LAT_W'(1);
  // high when this decrement takes the count to zero
  assign zero = dec && count <= LAT_W'(1);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin CPU/loader access to one memory port; ARB_LDR_BURST_EN adds ldr_lock
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2
) (
  input logic clock,
  input logic clear,
`ifdef ARB_LDR_BURST_EN
  input logic ldr_lock,
`endif
  mem_bus_arbiter_if.slave bus
);
  state_t            state, state_nx;
  logic              owner_q, we_q, last_owner, lock_q, cpu_done_q, ldr_done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              eff_cpu, win, win_ldr, lat_zero;
  assign eff_cpu = bus.cpu_req & ~bus.halt;
  assign win     = eff_cpu | bus.ldr_req;
  assign win_ldr = bus.ldr_req & (~eff_cpu | last_owner == OWN_CPU | lock_q);
  lat_counter u_lat (
    .clock(clock),
    .clear(clear),
    .load (state == ST_ISSUE),
    .dec  (state == ST_WAIT),
    .value(LAT_W'(MEM_LAT - 1)),
    .zero (lat_zero)
  );
  // state register
  always_ff @(posedge clock or posedge clear)
    if (clear) state <= ST_IDLE;
    else state <= state_nx;
  // next state: a single-cycle latency skips WAIT entirely
  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE:  state_nx = win ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nx = MEM_LAT == 1 ? ST_RESP : ST_WAIT;
      ST_WAIT:  state_nx = lat_zero ? ST_RESP : ST_WAIT;
      default:  state_nx = ST_IDLE;
    endcase
  end
  // latch the winner's request, capture read data and register the done pulse
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      owner_q    <= OWN_CPU;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      last_owner <= OWN_LDR;
      cpu_done_q <= 1'b0;
      ldr_done_q <= 1'b0;
    end else begin
      cpu_done_q <= state == ST_RESP && owner_q == OWN_CPU;
      ldr_done_q <= state == ST_RESP && owner_q == OWN_LDR;
      if (state == ST_IDLE && win) begin
        owner_q <= win_ldr ? OWN_LDR : OWN_CPU;
        we_q    <= win_ldr ? bus.ldr_we : bus.cpu_we;
        addr_q  <= win_ldr ? bus.ldr_addr : bus.cpu_addr;
        wdata_q <= win_ldr ? bus.ldr_wdata : bus.cpu_wdata;
      end
      if (state == ST_RESP) begin
        last_owner <= owner_q;
        if (!we_q) rdata_q <= bus.mem_rdata;
      end
    end
`ifdef ARB_LDR_BURST_EN
  // remember whether the loader asked to keep the bus at the end of its access
  always_ff @(posedge clock or posedge clear)
    if (clear) lock_q <= 1'b0;
    else if (state == ST_RESP) lock_q <= owner_q == OWN_LDR && ldr_lock;
`else
  assign lock_q = 1'b0;
`endif
  assign bus.mem_en    = state == ST_ISSUE;
  assign bus.mem_we    = state == ST_ISSUE && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = state != ST_IDLE;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.ldr_done  = ldr_done_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of grant order, latency, halt masking and reset abort
module tb_mem_bus_arbiter;
  logic       clock = 1'b0;
  logic       clear = 1'b1;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] rd_a = '0;
  int         rd_cnt = 0;
  logic [7:0] g [8];
  int         ng, k, bad, d1, d7, e1, e7;
  logic       cre, lre;
`ifdef ARB_LDR_BURST_EN
  logic       ldr_lock = 1'b0;
`endif
  mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();
  mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus7 ();
  always #5 clock = ~clock;
  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(2)) dut (
    .clock(clock),
    .clear(clear),
`ifdef ARB_LDR_BURST_EN
    .ldr_lock(ldr_lock),
`endif
    .bus(bus)
  );
  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) dut1 (
    .clock(clock),
    .clear(clear),
`ifdef ARB_LDR_BURST_EN
    .ldr_lock(1'b0),
`endif
    .bus(bus1)
  );
  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(7)) dut7 (
    .clock(clock),
    .clear(clear),
`ifdef ARB_LDR_BURST_EN
    .ldr_lock(1'b0),
`endif
    .bus(bus7)
  );
  function automatic logic [7:0] mem_val(logic [7:0] a);
    return a == 8'h12 ? 8'hA5 : a ^ 8'h5A;
  endfunction
  // memory model: read data valid only in the cycle MEM_LAT=2 after mem_en
  always @(posedge clock) begin
    if (bus.mem_en) begin
      rd_a   <= bus.mem_addr;
      rd_cnt <= 2;
    end else if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
  end
  assign bus.mem_rdata  = rd_cnt == 1 ? mem_val(rd_a) : 8'hEE;
  assign bus1.mem_rdata = 8'h00;
  assign bus7.mem_rdata = 8'h00;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask
  function automatic logic [31:0] outs();
    return {3'b0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata,
            bus.cpu_done, bus.ldr_done, bus.busy};
  endfunction
  initial begin
    {bus.cpu_req, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata, bus.ldr_req, bus.ldr_we, bus.ldr_addr, bus.ldr_wdata, bus.halt} = '0;
    {bus1.cpu_req, bus1.cpu_we, bus1.cpu_addr, bus1.cpu_wdata, bus1.ldr_req, bus1.ldr_we, bus1.ldr_addr, bus1.ldr_wdata, bus1.halt} = '0;
    {bus7.cpu_req, bus7.cpu_we, bus7.cpu_addr, bus7.cpu_wdata, bus7.ldr_req, bus7.ldr_we, bus7.ldr_addr, bus7.ldr_wdata, bus7.halt} = '0;
    repeat (2) @(negedge clock);
    check("reset_outs", outs(), 32'h0);
    clear = 1'b0;
    // single CPU read of 0x12, sampled at the end of cycle 0
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'h12;
    @(negedge clock);
    check("t1_c1_issue", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.busy}, {1'b1, 1'b0, 8'h12, 1'b1});
    @(negedge clock);
    check("t1_c2_wait", {bus.mem_en, bus.busy, bus.cpu_done}, 3'b010);
    @(negedge clock);
    check("t1_c3_resp", {bus.mem_en, bus.busy, bus.cpu_done}, 3'b010);
    @(negedge clock);
    check("t1_c4_done", {bus.cpu_done, bus.ldr_done, bus.busy}, 3'b100);
    check("t1_c4_rdata", bus.rdata, 8'hA5);
    bus.cpu_req = 1'b0;
    @(negedge clock);
    check("t1_c5_idle", {bus.cpu_done, bus.busy, bus.mem_addr}, {2'b00, 8'h12});
    // both requesting from reset: strict alternation starting with CPU
    pulse_clear();
    bus.cpu_addr = 8'h20; bus.ldr_addr = 8'h30;
    bus.cpu_req = 1'b1; bus.ldr_req = 1'b1;
    ng = 0; bad = 0; cre = 1'b0; lre = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      if (cre) begin bus.cpu_req = 1'b1; cre = 1'b0; end
      if (lre) begin bus.ldr_req = 1'b1; lre = 1'b0; end
      if (bus.mem_en && ng < 8) begin g[ng] = bus.mem_addr; ng++; end
      if (bus.cpu_done && bus.ldr_done) bad++;
      if (bus.cpu_done) begin bus.cpu_req = 1'b0; cre = 1'b1; end
      if (bus.ldr_done) begin bus.ldr_req = 1'b0; lre = 1'b1; end
    end
    check("t2_grant_order", {g[0], g[1], g[2], g[3]}, 32'h20302030);
    check("t2_no_overlap", bad, 0);
    bus.cpu_req = 1'b0; bus.ldr_req = 1'b0;
    repeat (6) @(negedge clock);
    // halted CPU is masked; loader write goes through
    bus.halt = 1'b1; bus.cpu_req = 1'b1; bus.cpu_addr = 8'h40;
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 8'h05; bus.ldr_wdata = 8'h3C;
    ng = 0; k = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (bus.mem_en) begin
        ng++;
        check("t3_ldr_write", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 8'h05, 8'h3C});
      end
      if (!bus.mem_en && bus.mem_we) bad++;
      if (bus.cpu_done) k++;
      if (bus.ldr_done) bus.ldr_req = 1'b0;
    end
    check("t3_one_grant", ng, 1);
    check("t3_no_cpu_done", k, 0);
    check("t3_we_outside_issue", bad, 0);
    bus.halt = 1'b0;
    k = 0;
    while (!bus.mem_en && k < 6) begin @(negedge clock); k++; end
    check("t3_cpu_after_halt", {bus.mem_en, bus.mem_addr}, {1'b1, 8'h40});
    k = 0;
    while (!bus.cpu_done && k < 8) begin @(negedge clock); k++; end
    check("t3_cpu_read", {bus.cpu_done, bus.rdata}, {1'b1, 8'h1A});
    bus.cpu_req = 1'b0;
    // clear during WAIT of a loader read abandons it
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 8'h07;
    k = 0;
    while (!bus.mem_en && k < 6) begin @(negedge clock); k++; end
    check("t4_ldr_issue", {bus.mem_en, bus.mem_addr}, {1'b1, 8'h07});
    @(negedge clock);
    check("t4_in_wait", {bus.busy, bus.mem_en}, 2'b10);
    clear = 1'b1;
    #1;
    check("t4_clear_outs", outs(), 32'h0);
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'h20;
    @(negedge clock);
    clear = 1'b0;
    k = 0; bad = 0;
    while (!bus.mem_en && k < 8) begin
      @(negedge clock);
      k++;
      if (bus.ldr_done) bad++;
    end
    check("t4_tie_to_cpu", {bus.mem_en, bus.mem_addr}, {1'b1, 8'h20});
    check("t4_no_ldr_done", bad, 0);
    bus.cpu_req = 1'b0; bus.ldr_req = 1'b0;
    repeat (6) @(negedge clock);
    // latency extremes: MEM_LAT=1 and MEM_LAT=7
    bus1.cpu_req = 1'b1; bus1.cpu_addr = 8'h11;
    bus7.cpu_req = 1'b1; bus7.cpu_addr = 8'h77;
    d1 = 0; d7 = 0; e1 = 0; e7 = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (bus1.mem_en) e1++;
      if (bus7.mem_en) e7++;
      if (bus1.cpu_done && d1 == 0) begin d1 = i; bus1.cpu_req = 1'b0; end
      if (bus7.cpu_done && d7 == 0) begin d7 = i; bus7.cpu_req = 1'b0; end
    end
    check("t5_lat1_done_cycle", d1, 3);
    check("t5_lat7_done_cycle", d7, 9);
    check("t5_lat1_en_count", e1, 1);
    check("t5_lat7_en_count", e7, 1);
`ifdef ARB_LDR_BURST_EN
    // loader lock overrides round-robin until released
    pulse_clear();
    ldr_lock = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'h20;
    bus.ldr_req = 1'b1; bus.ldr_addr = 8'h30;
    ng = 0;
    for (int i = 0; i < 40 && ng < 6; i++) begin
      @(negedge clock);
      if (bus.mem_en) begin
        g[ng] = bus.mem_addr;
        ng++;
        if (ng == 5) ldr_lock = 1'b0;
      end
    end
    check("t6_first_cpu", g[0], 8'h20);
    check("t6_ldr_burst", {g[1], g[2], g[3], g[4]}, 32'h30303030);
    check("t6_cpu_after_unlock", g[5], 8'h20);
    bus.cpu_req = 1'b0; bus.ldr_req = 1'b0;
    repeat (6) @(negedge clock);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single program/data memory port between two requesters: the CPU fetch/execute path (CPU) and the program loader (LDR) that writes code before and while the CPU is halted.
- One transaction in flight at a time, using a req/done handshake.
- Round-robin between the two requesters; CPU requests are masked while the controller reports halt.
- Sits between the control unit/datapath and the memory macro, which has a fixed read latency.

Parameters:
ADDR_W, 8, address width
DATA_W, 8, data width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata (legal 1..7)

Ports:
clock  in  1  single system clock, rising edge
clear  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU request; held until cpu_done
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_done  out  1  one-cycle completion pulse to CPU
ldr_req  in  1  loader request; held until ldr_done
ldr_we  in  1  loader write/read
ldr_addr  in  ADDR_W  loader address
ldr_wdata  in  DATA_W  loader write data
ldr_done  out  1  one-cycle completion pulse to loader
halt  in  1  CPU halted; masks cpu_req
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
rdata  out  DATA_W  last read data captured; held until the next read completes
busy  out  1  high from ISSUE through RESP

Behaviour:
- Reset (async clear=1): state IDLE. All outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, rdata, cpu_done, ldr_done, busy. last_owner resets to LDR, so the CPU wins the first tie.
- Reset mid-transaction: outputs clear immediately, the in-flight access is abandoned, and no done pulse is issued.
- States:
  - IDLE: sample eff_cpu = cpu_req & ~halt, and ldr_req.
    - Neither asserted: stay in IDLE.
    - One asserted: that requester wins.
    - Both asserted: the requester that is not last_owner wins.
    - On a win, latch owner, we, addr and wdata, then go to ISSUE.
  - ISSUE (1 cycle): mem_en=1, mem_we/mem_addr/mem_wdata driven from the latched fields; load the latency counter with MEM_LAT-1; go to WAIT (if MEM_LAT=1, go straight to RESP).
  - WAIT: mem_en=0; decrement the counter; at 0 go to RESP. The cycle entering RESP is the cycle in which mem_rdata is valid.
  - RESP (1 cycle): if the access is a read, rdata <= mem_rdata at the end of the cycle. The owner's done pulse is registered, so it appears in the following cycle; last_owner <= owner; go to IDLE.
- Latency: with req sampled at the end of cycle T, mem_en is high in T+1 and done is high in T+2+MEM_LAT. With MEM_LAT=2, done is in T+4. rdata is valid in the same cycle as done.
- Throughput: one transaction per MEM_LAT+3 cycles per requester.
- Handshake:
  - The requester holds req/we/addr/wdata until it sees done.
  - It drops req on the edge after done; a req still high in IDLE is a new request.
  - req dropped mid-transaction does not abort it; done still pulses.
  - Changes to we/addr/wdata after the IDLE sample are ignored.
- halt rising during a CPU transaction: that transaction completes normally; only new CPU requests are masked.
- mem_addr and mem_wdata hold their last values between transactions. mem_we is 0 outside ISSUE.
- Write transactions leave rdata unchanged.

Optional Feature:
- Macro: ARB_LDR_BURST_EN.
- With the macro: adds input port ldr_lock (1 bit). If ldr_lock=1 while LDR owns a transaction, the next IDLE grants LDR whenever ldr_req=1, overriding round-robin; CPU starvation is allowed while lock is held.
- Without the macro: no ldr_lock port; pure round-robin as above.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding constants ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP (2 bits)
  - owner constants OWN_CPU=0, OWN_LDR=1
  - counter width constant LAT_W=3
- One sub-module, lat_counter: loadable down-counter with zero flag, async clear.

Test Plan:
- cpu_req=1 read of addr 0x12 with memory[0x12]=0xA5, MEM_LAT=2, sampled end of cycle 0 -> mem_en in cycle 1 with mem_addr=0x12, cpu_done and rdata=0xA5 in cycle 4, busy cycles 1-3.
- cpu_req and ldr_req both high from reset, each holding then dropping req and reasserting after its done -> grant order CPU, LDR, CPU, LDR; no done overlap.
- halt=1, cpu_req=1, ldr write 0x3C to addr 0x05 -> only LDR is served, mem_we=1 with addr 0x05 and data 0x3C, cpu_done never pulses; after halt=0 the CPU is served next.
- clear asserted in the WAIT state of an LDR read -> all outputs 0 the same cycle, no ldr_done; after release the first tie is granted to CPU.
- MEM_LAT=1, CPU read -> done in cycle T+3; MEM_LAT=7 -> done in T+9, with mem_en high exactly one cycle in each case.
- ARB_LDR_BURST_EN defined, ldr_lock=1, both requesting continuously -> four consecutive LDR grants; after ldr_lock=0 the next grant goes to CPU.
